// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps {A,B,C} through 0..7, samples F after DWELL cycles per vector and checks it against EXPECTED.
// Optional TT_SEQ_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sequencer #(
    parameter logic [7:0] EXPECTED = 8'b0110_1001,
    parameter int         DWELL    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       F,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail_idx
);
`ifdef TT_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t        state, next_state;
    logic [2:0]    idx;
    logic [CW-1:0] dwell_cnt;
    logic          sample, miss, stop;

    assign sample = state == S_DRIVE && dwell_cnt == LAST;
    assign miss   = sample && F != EXPECTED[idx];
    assign stop   = sample && (idx == 3'd7 || (STOP_ON_FAIL && miss));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state == S_IDLE  ? (start ? S_DRIVE : S_IDLE) :
                     state == S_DRIVE ? (stop ? S_DONE : S_DRIVE) : S_IDLE;
    end

    // The last vector stays on A/B/C through the done cycle.
    always_comb begin
        busy      = state == S_DRIVE;
        done      = state == S_DONE;
        {A, B, C} = state == S_IDLE ? 3'b000 : idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            dwell_cnt      <= '0;
            captured       <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
        end else if (state == S_IDLE && start) begin
            idx            <= '0;
            dwell_cnt      <= '0;
            captured       <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
        end else if (state == S_DRIVE) begin
            if (sample) begin
                captured[idx] <= F;
                if (miss) begin
                    fail_count <= fail_count + 4'd1;
                    if (fail_count == 4'd0) first_fail_idx <= idx;
                end
                // pass is settled on the final sampling edge so it is valid during done.
                if (stop) begin
                    pass <= fail_count == 4'd0 && !miss;
                end else begin
                    idx       <= idx + 3'd1;
                    dwell_cnt <= '0;
                end
            end else begin
                dwell_cnt <= dwell_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: random truth tables against a sweep-level reference model.
module tb_truth_table_sequencer;
    localparam int         DW  = 2;
    localparam logic [7:0] EXP = 8'h69;
`ifdef TT_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 0, rst = 1, start = 0, F;
    logic       A, B, C, busy, done, pass;
    logic [7:0] captured;
    logic [3:0] fail_count;
    logic [2:0] first_fail_idx;
    logic [7:0] fn_tt = 8'h00;
    int         total = 0, bad = 0;

    truth_table_sequencer #(.EXPECTED(EXP), .DWELL(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .F(F),
        .A(A), .B(B), .C(C), .busy(busy), .done(done), .pass(pass),
        .captured(captured), .fail_count(fail_count), .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;
    assign F = fn_tt[{A, B, C}];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_abc"}, 32'({A, B, C}), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_cap"}, 32'(captured), 0);
        check({tag, "_fails"}, 32'(fail_count), 0);
        check({tag, "_ffi"}, 32'(first_fail_idx), 0);
    endtask

    // One sweep for table t; start is re-pulsed at cycle poke (negative = never).
    task automatic sweep(input logic [7:0] t, input int poke);
        logic [7:0] diff, cap;
        int ffi, lat, fails, n;
        fn_tt = t;
        diff  = t ^ EXP;
        ffi   = 0;
        for (int i = 7; i >= 0; i--) if (diff[i]) ffi = i;
        fails = $countones(diff);
        cap   = t;
        lat   = 8 * DW;
        if (STOP && diff != 0) begin
            fails = 1;
            lat   = (ffi + 1) * DW;
            cap   = t & 8'((9'd1 << (ffi + 1)) - 9'd1);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (!done && n < 200) begin
            if (n % DW == 0 || n == poke) begin
                check("abc", 32'({A, B, C}), n / DW);
                check("busy", 32'(busy), 1);
            end
            start = n == poke;
            @(negedge clk);
            n++;
        end
        start = 0;
        check("latency", n, lat);
        check("done_busy", 32'(busy), 0);
        check("done_abc", 32'({A, B, C}), lat / DW - 1);
        check("cap", 32'(captured), 32'(cap));
        check("fails", 32'(fail_count), fails);
        check("ffi", 32'(first_fail_idx), ffi);
        check("pass", 32'(pass), diff == 0 ? 1 : 0);
        @(negedge clk);
        check("post_done", 32'(done), 0);
        check("post_abc", 32'({A, B, C}), 0);
        check("post_pass", 32'(pass), diff == 0 ? 1 : 0);
    endtask

    initial begin
        int first, second, cnt, n;
        start = 1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 0;
        start = 0;
        @(negedge clk);

        sweep(EXP, -1);
        sweep(8'h00, -1);
        sweep(~EXP, -1);
        sweep(EXP, 3 * DW);
        sweep(8'h01, 3 * DW + 1);
        for (int r = 0; r < 10; r++) sweep(8'($urandom), -1);

        // abort mid-sweep at idx 5
        fn_tt = 8'h00;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (5 * DW) @(negedge clk);
        check("abort_abc", 32'({A, B, C}), 5);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_reset_values("abort");
        cnt = 0;
        repeat (8 * DW) begin
            @(negedge clk);
            cnt += done ? 1 : 0;
        end
        check("abort_no_done", cnt, 0);
        sweep(EXP, -1);

        // start held high: back-to-back sweeps with cleared results
        fn_tt = ~EXP;
        start = 1;
        first = -1;
        second = -1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (cnt == 0) first = i;
                else if (cnt == 1) second = i;
                cnt++;
            end
            if (i == 8 * DW + 2) begin
                check("restart_cap", 32'(captured), 0);
                check("restart_fails", 32'(fail_count), 0);
                check("restart_busy", 32'(busy), 1);
            end
        end
        start = 0;
        check("hold_first", first, 8 * DW);
        check("hold_second", second, 16 * DW + 2);
        check("hold_count", cnt, 2);
        n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hold_drain", n < 200 ? 1 : 0, 1);
        @(negedge clk);
        check("final_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
